// File: rtl/btb_write_scheduler_pkg.sv
// Shared BTB geometry, entry field offsets and scheduler state encoding.
// Entry layout is {valid, state[1:0], tag[1:0], target[12:0]}.
package btb_write_scheduler_pkg;

    localparam int BTB_ADDR_W = 11;
    localparam int BTB_DATA_W = 18;
    localparam int BTB_DEPTH  = 4;
    localparam int BTB_CNT_W  = 8;

    localparam int BTB_TARGET_LSB = 0;
    localparam int BTB_TAG_LSB    = 13;
    localparam int BTB_STATE_LSB  = 15;
    localparam int BTB_VALID_BIT  = 17;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/btb_write_scheduler_if.sv
// Request/BTB-write bundle between the update requesters and the write scheduler.
// master = requester side, slave = scheduler side.
interface btb_write_scheduler_if
    import btb_write_scheduler_pkg::*;
#(
    parameter int ADDR_W = BTB_ADDR_W,
    parameter int DATA_W = BTB_DATA_W,
    parameter int DEPTH  = BTB_DEPTH,
    parameter int CNT_W  = BTB_CNT_W
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              e_wen;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data;
    logic              btb_wen;
    logic [ADDR_W-1:0] btb_addr;
    logic [DATA_W-1:0] btb_data;
    logic              btb_ready;
    logic [CNT_W-1:0]  drop_count;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        output flush, e_wen, e_addr, e_data, d_wen, d_addr, d_data,
        input  btb_wen, btb_addr, btb_data, btb_ready, drop_count, fifo_level
    );

    modport slave (
        input  flush, e_wen, e_addr, e_data, d_wen, d_addr, d_data,
        output btb_wen, btb_addr, btb_data, btb_ready, drop_count, fifo_level
    );

endinterface

// File: rtl/btb_write_scheduler_sync_fifo.sv
// Small register FIFO: up to two pushes and one pop per cycle, sync clear, level output.
// Head is combinational; a full FIFO may push into the slot freed by a same-cycle pop.
module btb_write_scheduler_sync_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       push0_i,
    input  logic [WIDTH-1:0]           dat0_i,
    input  logic                       push1_i,
    input  logic [WIDTH-1:0]           dat1_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d, wr1;
    logic [LVL_W-1:0] level_q, level_d;
    logic [1:0]       n_push;

    always_comb begin
        n_push  = {1'b0, push0_i} + {1'b0, push1_i};
        wr1     = push0_i ? (wr_q + PTR_ONE) : wr_q;
        wr_d    = wr_q + PTR_W'(n_push);
        rd_d    = rd_q + PTR_W'(pop_i);
        level_d = level_q + LVL_W'(n_push) - LVL_W'(pop_i);
        if (clr_i) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_i) begin
            if (push0_i) mem_q[wr_q] <= dat0_i;
            if (push1_i) mem_q[wr1]  <= dat1_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign level_o = level_q;
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/btb_write_scheduler.sv
// Sole owner of the BTB write port: clear sweep after reset/flush, then E-before-D updates.
// One registered write per cycle; an empty FIFO is bypassed; excess requests are dropped and counted.
module btb_write_scheduler
    import btb_write_scheduler_pkg::*;
#(
    parameter int ADDR_W = BTB_ADDR_W,
    parameter int DATA_W = BTB_DATA_W,
    parameter int DEPTH  = BTB_DEPTH,
    parameter int CNT_W  = BTB_CNT_W
) (
    input logic                  clk,
    input logic                  rst,
    btb_write_scheduler_if.slave bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [LVL_W:0]    CAP_FULL = (LVL_W+1)'(DEPTH + 1);
    localparam logic [LVL_W:0]    CAP_ONE  = (LVL_W+1)'(1);
    localparam logic [LVL_W:0]    CAP_TWO  = (LVL_W+1)'(2);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic              run_ok, e_acc, d_acc, e_rej, d_rej;
    logic              have_first, have_second;
    logic [ENT_W-1:0]  e_ent, d_ent, first_ent;
    logic [LVL_W:0]    cap;
    logic [1:0]        drop_inc;
    logic [CNT_W:0]    drop_sum;

    logic              f_push0, f_push1, f_pop, f_empty;
    logic [ENT_W-1:0]  f_dat0, f_dat1, f_head;
    logic [LVL_W-1:0]  f_level;

    assign e_ent = {bus.e_addr, bus.e_data};
    assign d_ent = {bus.d_addr, bus.d_data};

    // Capacity counts the slot that the output register frees this cycle.
    always_comb begin
        run_ok      = (state_q == ST_RUN) && !bus.flush;
        cap         = CAP_FULL - {1'b0, f_level};
        e_acc       = run_ok && bus.e_wen && (cap >= CAP_ONE);
        d_acc       = run_ok && bus.d_wen && (cap >= (e_acc ? CAP_TWO : CAP_ONE));
        e_rej       = run_ok && bus.e_wen && !e_acc;
        d_rej       = run_ok && bus.d_wen && !d_acc;
        have_first  = e_acc || d_acc;
        have_second = e_acc && d_acc;
        first_ent   = e_acc ? e_ent : d_ent;
        f_pop       = run_ok && !f_empty;
        f_push0     = 1'b0;
        f_push1     = 1'b0;
        f_dat0      = first_ent;
        f_dat1      = d_ent;
        if (f_empty) begin
            f_push0 = have_second;
            f_dat0  = d_ent;
        end else begin
            f_push0 = have_first;
            f_push1 = have_second;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_INIT: begin
                wen_d  = 1'b1;
                addr_d = ptr_q;
                data_d = '0;
                ptr_d  = ptr_q + ADDR_ONE;
                if (ptr_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!f_empty) begin
                    wen_d            = 1'b1;
                    {addr_d, data_d} = f_head;
                end else if (have_first) begin
                    wen_d            = 1'b1;
                    {addr_d, data_d} = first_ent;
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (bus.flush) begin
            state_d = ST_INIT;
            ptr_d   = '0;
            wen_d   = 1'b0;
            addr_d  = '0;
            data_d  = '0;
        end
        ready_d = (state_q == ST_RUN) && !bus.flush;
    end

    always_comb begin
        drop_inc = {1'b0, e_rej} + {1'b0, d_rej};
        drop_sum = {1'b0, drop_q} + {{(CNT_W-1){1'b0}}, drop_inc};
        drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
        end
    end

    btb_write_scheduler_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bus.flush),
        .push0_i (f_push0),
        .dat0_i  (f_dat0),
        .push1_i (f_push1),
        .dat1_i  (f_dat1),
        .pop_i   (f_pop),
        .head_o  (f_head),
        .level_o (f_level),
        .empty_o (f_empty)
    );

    assign bus.btb_wen    = wen_q;
    assign bus.btb_addr   = addr_q;
    assign bus.btb_data   = data_q;
    assign bus.btb_ready  = ready_q;
    assign bus.drop_count = drop_q;
    assign bus.fifo_level = f_level;

endmodule

// File: tb/tb_btb_write_scheduler.sv
// Bench for btb_write_scheduler: hand-derived vector table, corner sequences, and a
// queue-based reference model checked every cycle under random traffic.
module tb_btb_write_scheduler;
    import btb_write_scheduler_pkg::*;

    localparam int DEP    = 4;
    localparam int NSWEEP = 2048;
    localparam int DMAX   = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btb_write_scheduler_if bus ();

    btb_write_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: q holds accepted writes not yet on the bus.
    logic [28:0] q [$];
    logic        m_wen, m_ready, m_sweep;
    logic [10:0] m_addr;
    logic [17:0] m_data;
    int          m_drop, m_idx;

    typedef struct {
        logic        ew;
        logic [10:0] ea;
        logic [17:0] ed;
        logic        dw;
        logic [10:0] da;
        logic [17:0] dd;
        logic        x_wen;
        logic [10:0] x_addr;
        logic [17:0] x_data;
        int          x_lvl;
        int          x_drop;
    } vec_t;
    vec_t tab [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wen = 0; m_addr = 0; m_data = 0; m_ready = 0;
        m_drop = 0; m_sweep = 1; m_idx = 0;
    endtask

    task automatic model_step(input logic f, input logic ew, input logic [10:0] ea,
                              input logic [17:0] ed, input logic dw, input logic [10:0] da,
                              input logic [17:0] dd);
        int cap;
        if (f) begin
            q.delete();
            m_wen = 0; m_addr = 0; m_data = 0; m_ready = 0;
            m_sweep = 1; m_idx = 0;
        end else if (m_sweep) begin
            m_wen = 1; m_addr = 11'(m_idx); m_data = 0; m_ready = 0;
            m_idx++;
            if (m_idx == NSWEEP) m_sweep = 0;
        end else begin
            m_ready = 1;
            cap = DEP - q.size() + 1;
            if (ew) begin
                if (cap >= 1) begin q.push_back({ea, ed}); cap--; end
                else m_drop++;
            end
            if (dw) begin
                if (cap >= 1) begin q.push_back({da, dd}); cap--; end
                else m_drop++;
            end
            if (m_drop > DMAX) m_drop = DMAX;
            if (q.size() > 0) begin
                {m_addr, m_data} = q.pop_front();
                m_wen = 1;
            end else begin
                m_wen = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("wen", 32'(bus.btb_wen), 32'(m_wen));
        if (m_wen) begin
            chk("addr", 32'(bus.btb_addr), 32'(m_addr));
            chk("data", 32'(bus.btb_data), 32'(m_data));
        end
        chk("ready", 32'(bus.btb_ready), 32'(m_ready));
        chk("drop", 32'(bus.drop_count), 32'(m_drop));
        chk("level", 32'(bus.fifo_level), 32'(q.size()));
    endtask

    task automatic tick(input logic f, input logic ew, input logic [10:0] ea,
                        input logic [17:0] ed, input logic dw, input logic [10:0] da,
                        input logic [17:0] dd);
        bus.flush = f;
        bus.e_wen = ew; bus.e_addr = ea; bus.e_data = ed;
        bus.d_wen = dw; bus.d_addr = da; bus.d_data = dd;
        @(posedge clk);
        model_step(f, ew, ea, ed, dw, da, dd);
        #1;
        check_model();
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd_tick(input int pe, input int pd, input int pf);
        tick(($urandom_range(0, 999) < pf), ($urandom_range(0, 99) < pe), 11'($urandom),
             18'($urandom), ($urandom_range(0, 99) < pd), 11'($urandom), 18'($urandom));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wen"},   32'(bus.btb_wen),    0);
        chk({tag, "_addr"},  32'(bus.btb_addr),   0);
        chk({tag, "_data"},  32'(bus.btb_data),   0);
        chk({tag, "_ready"}, 32'(bus.btb_ready),  0);
        chk({tag, "_drop"},  32'(bus.drop_count), 0);
        chk({tag, "_level"}, 32'(bus.fifo_level), 0);
    endtask

    task automatic add_vec(input logic ew, input int ea, input int ed, input logic dw,
                           input int da, input int dd, input logic xw, input int xa,
                           input int xd, input int xl, input int xdr);
        vec_t v;
        v.ew = ew; v.ea = 11'(ea); v.ed = 18'(ed);
        v.dw = dw; v.da = 11'(da); v.dd = 18'(dd);
        v.x_wen = xw; v.x_addr = 11'(xa); v.x_data = 18'(xd);
        v.x_lvl = xl; v.x_drop = xdr;
        tab.push_back(v);
    endtask

    function automatic int ea_k(input int k); return 'h100 + k; endfunction
    function automatic int ed_k(input int k); return 'h30000 | k; endfunction
    function automatic int da_k(input int k); return 'h200 + k; endfunction
    function automatic int dd_k(input int k); return 'h10000 | k; endfunction

    initial begin
        int guard;

        // Single E write, then idle.
        add_vec(1, 'h123, 'h2ABCD, 0, 0, 0,      1, 'h123, 'h2ABCD, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0);
        // Simultaneous E and D: E first.
        add_vec(1, 5, 'h00111, 1, 9, 'h00222,    1, 5, 'h00111, 1, 0);
        add_vec(0, 0, 0, 0, 0, 0,                1, 9, 'h00222, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0);
        // Six cycles of E+D into a 4-deep FIFO: D dropped in cycles 5 and 6.
        add_vec(1, ea_k(1), ed_k(1), 1, da_k(1), dd_k(1), 1, ea_k(1), ed_k(1), 1, 0);
        add_vec(1, ea_k(2), ed_k(2), 1, da_k(2), dd_k(2), 1, da_k(1), dd_k(1), 2, 0);
        add_vec(1, ea_k(3), ed_k(3), 1, da_k(3), dd_k(3), 1, ea_k(2), ed_k(2), 3, 0);
        add_vec(1, ea_k(4), ed_k(4), 1, da_k(4), dd_k(4), 1, da_k(2), dd_k(2), 4, 0);
        add_vec(1, ea_k(5), ed_k(5), 1, da_k(5), dd_k(5), 1, ea_k(3), ed_k(3), 4, 1);
        add_vec(1, ea_k(6), ed_k(6), 1, da_k(6), dd_k(6), 1, da_k(3), dd_k(3), 4, 2);
        add_vec(0, 0, 0, 0, 0, 0,                1, ea_k(4), ed_k(4), 3, 2);
        add_vec(0, 0, 0, 0, 0, 0,                1, da_k(4), dd_k(4), 2, 2);
        add_vec(0, 0, 0, 0, 0, 0,                1, ea_k(5), ed_k(5), 1, 2);
        add_vec(0, 0, 0, 0, 0, 0,                1, ea_k(6), ed_k(6), 0, 2);
        add_vec(0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 2);

        rst = 1'b1;
        bus.flush = 0; bus.e_wen = 0; bus.e_addr = 0; bus.e_data = 0;
        bus.d_wen = 0; bus.d_addr = 0; bus.d_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        model_reset();

        // Power-up sweep.
        for (int i = 0; i < NSWEEP; i++) idle();
        chk("sweep_last_addr", 32'(bus.btb_addr), 2047);
        chk("sweep_last_ready", 32'(bus.btb_ready), 0);
        idle();
        chk("ready_after_sweep", 32'(bus.btb_ready), 1);
        chk("idle_after_sweep", 32'(bus.btb_wen), 0);

        foreach (tab[i]) begin
            tick(0, tab[i].ew, tab[i].ea, tab[i].ed, tab[i].dw, tab[i].da, tab[i].dd);
            chk($sformatf("tab%0d_wen", i), 32'(bus.btb_wen), 32'(tab[i].x_wen));
            if (tab[i].x_wen) begin
                chk($sformatf("tab%0d_addr", i), 32'(bus.btb_addr), 32'(tab[i].x_addr));
                chk($sformatf("tab%0d_data", i), 32'(bus.btb_data), 32'(tab[i].x_data));
            end
            chk($sformatf("tab%0d_level", i), 32'(bus.fifo_level), 32'(tab[i].x_lvl));
            chk($sformatf("tab%0d_drop", i), 32'(bus.drop_count), 32'(tab[i].x_drop));
        end

        // Flush with three entries queued.
        for (int k = 1; k <= 3; k++)
            tick(0, 1, 11'(ea_k(10 + k)), 18'(ed_k(k)), 1, 11'(da_k(10 + k)), 18'(dd_k(k)));
        chk("pre_flush_level", 32'(bus.fifo_level), 3);
        tick(1, 1, 11'h7AA, 18'h1, 1, 11'h7BB, 18'h2);
        chk("flush_wen", 32'(bus.btb_wen), 0);
        chk("flush_ready", 32'(bus.btb_ready), 0);
        chk("flush_level", 32'(bus.fifo_level), 0);
        chk("flush_drop_kept", 32'(bus.drop_count), 2);
        rnd_tick(80, 80, 0);
        chk("resweep_first_addr", 32'(bus.btb_addr), 0);
        chk("resweep_first_wen", 32'(bus.btb_wen), 1);
        for (int i = 1; i < NSWEEP; i++) rnd_tick(80, 80, 0);
        chk("resweep_drop_unchanged", 32'(bus.drop_count), 2);
        chk("resweep_ready_low", 32'(bus.btb_ready), 0);
        idle();
        chk("resweep_ready_high", 32'(bus.btb_ready), 1);

        // Random traffic with rare flushes.
        for (int i = 0; i < 1500; i++) rnd_tick(70, 60, 2);
        guard = 0;
        while ((m_sweep || !m_ready) && guard < 3000) begin
            idle();
            guard++;
        end
        chk("settle_ready", 32'(bus.btb_ready), 1);

        // Saturate the drop counter.
        for (int i = 0; i < 300; i++)
            tick(0, 1, 11'($urandom), 18'($urandom), 1, 11'($urandom), 18'($urandom));
        chk("drop_saturated", 32'(bus.drop_count), DMAX);
        for (int i = 0; i < 5; i++)
            tick(0, 1, 11'($urandom), 18'($urandom), 1, 11'($urandom), 18'($urandom));
        chk("drop_stays_saturated", 32'(bus.drop_count), DMAX);

        // Asynchronous reset in the middle of a sweep.
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) rnd_tick(50, 50, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset("midsweep_rst");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) idle();
        chk("post_rst_addr", 32'(bus.btb_addr), 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
